// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm engine: FSM encoding, time field widths and limits.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } alarm_state_t;

    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

    function automatic logic time_valid(input logic [HOUR_W-1:0] hour,
                                        input logic [MIN_W-1:0]  minute);
        return (hour <= HOUR_W'(HOUR_MAX)) && (minute <= MIN_W'(MIN_MAX));
    endfunction

endpackage

// File: rtl/multi_alarm_ctrl_beep_gen.sv
// Buzzer square-wave generator: 50% duty, BEEP_CYCLES clocks per half-period,
// starts high on restart and is held low while disabled.
module beep_gen #(
    parameter int BEEP_CYCLES = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic buzzy
);

    localparam int CNT_W = $clog2(BEEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            buzzy <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            buzzy <= 1'b1;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt   <= '0;
                buzzy <= ~buzzy;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt   <= '0;
            buzzy <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-alarm engine: alarm store, lowest-index match encoder and ring/snooze FSM.
// Optional per-alarm weekday mask enabled by defining ALARM_WEEKDAY_MASK_EN.
module multi_alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS       = 4,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10,
    parameter int BEEP_CYCLES      = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_min,
    input  logic [4:0]            cur_hour,
    input  logic [5:0]            cur_min,
`ifdef ALARM_WEEKDAY_MASK_EN
    input  logic [2:0]            cur_day,
    input  logic [6:0]            wr_days,
`endif
    input  logic                  wr_en,
    input  logic [2:0]            wr_idx,
    input  logic [4:0]            wr_hour,
    input  logic [5:0]            wr_min,
    input  logic                  wr_enable,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic                  ringing,
    output logic                  snoozed,
    output logic [2:0]            ring_idx,
    output logic [NUM_ALARMS-1:0] armed,
    output logic                  buzzy,
    output logic                  led
);

    localparam logic [5:0] SNOOZE_CNT  = 6'(SNOOZE_MIN);
    localparam logic [5:0] TIMEOUT_CNT = 6'(RING_TIMEOUT_MIN);

    logic [HOUR_W-1:0]     al_hour [NUM_ALARMS];
    logic [MIN_W-1:0]      al_min  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] al_en;
`ifdef ALARM_WEEKDAY_MASK_EN
    logic [6:0]            al_days [NUM_ALARMS];
`endif

    logic                  wr_ok;
    logic [NUM_ALARMS-1:0] day_ok;
    logic                  hit;
    logic [2:0]            hit_idx;
    logic                  disarm_active;

    alarm_state_t state, state_nxt;
    logic [2:0]   idx_nxt;
    logic [5:0]   ring_cnt, ring_cnt_nxt;
    logic [5:0]   snz_cnt, snz_cnt_nxt;

    // Out-of-range index or time rejects the whole write, including the arm bit.
    assign wr_ok = wr_en && ({29'd0, wr_idx} < NUM_ALARMS) && time_valid(wr_hour, wr_min);
    assign disarm_active = wr_ok && !wr_enable && (wr_idx == ring_idx);
    assign armed = al_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            al_en <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                al_hour[i] <= '0;
                al_min[i]  <= '0;
`ifdef ALARM_WEEKDAY_MASK_EN
                al_days[i] <= 7'h7F;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (wr_ok && (wr_idx == 3'(i))) begin
                    al_hour[i] <= wr_hour;
                    al_min[i]  <= wr_min;
                    al_en[i]   <= wr_enable;
`ifdef ALARM_WEEKDAY_MASK_EN
                    al_days[i] <= wr_days;
`endif
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
`ifdef ALARM_WEEKDAY_MASK_EN
            day_ok[i] = (cur_day <= 3'd6) && al_days[i][cur_day];
`else
            day_ok[i] = 1'b1;
`endif
        end
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (al_en[i] && day_ok[i] && (al_hour[i] == cur_hour) && (al_min[i] == cur_min)) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = ring_idx;
        ring_cnt_nxt = ring_cnt;
        snz_cnt_nxt  = snz_cnt;
        case (state)
            IDLE: begin
                if (tick_min && hit) begin
                    state_nxt    = RINGING;
                    idx_nxt      = hit_idx;
                    ring_cnt_nxt = '0;
                end
            end
            RINGING: begin
                if (dismiss || disarm_active) begin
                    state_nxt = IDLE;
                end else if (snooze) begin
                    state_nxt   = SNOOZED;
                    snz_cnt_nxt = SNOOZE_CNT;
                end else if (tick_min) begin
                    ring_cnt_nxt = ring_cnt + 6'd1;
                    if (ring_cnt_nxt == TIMEOUT_CNT) state_nxt = IDLE;
                end
            end
            SNOOZED: begin
                if (dismiss || disarm_active) begin
                    state_nxt = IDLE;
                end else if (tick_min) begin
                    snz_cnt_nxt = snz_cnt - 6'd1;
                    if (snz_cnt_nxt == 6'd0) begin
                        state_nxt    = RINGING;
                        ring_cnt_nxt = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Nothing is active in IDLE, so its index and counters read as zero.
        if (state_nxt == IDLE) begin
            idx_nxt      = '0;
            ring_cnt_nxt = '0;
            snz_cnt_nxt  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ring_idx <= '0;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            ringing  <= 1'b0;
            snoozed  <= 1'b0;
            led      <= 1'b0;
        end else begin
            state    <= state_nxt;
            ring_idx <= idx_nxt;
            ring_cnt <= ring_cnt_nxt;
            snz_cnt  <= snz_cnt_nxt;
            ringing  <= (state_nxt == RINGING);
            snoozed  <= (state_nxt == SNOOZED);
            led      <= (state_nxt != IDLE);
        end
    end

    // Driven from next-state so buzzy is already high on the first RINGING cycle.
    beep_gen #(
        .BEEP_CYCLES(BEEP_CYCLES)
    ) u_beep (
        .clk    (clk),
        .rst    (rst),
        .en     (state_nxt == RINGING),
        .restart((state_nxt == RINGING) && (state != RINGING)),
        .buzzy  (buzzy)
    );

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Bench for multi_alarm_ctrl: table of per-cycle vectors checked through a scoreboard queue.
module tb_multi_alarm_ctrl;

    localparam int NA = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick_min;
    logic [4:0]    cur_hour;
    logic [5:0]    cur_min;
`ifdef ALARM_WEEKDAY_MASK_EN
    logic [2:0]    cur_day;
    logic [6:0]    wr_days;
`endif
    logic          wr_en;
    logic [2:0]    wr_idx;
    logic [4:0]    wr_hour;
    logic [5:0]    wr_min;
    logic          wr_enable;
    logic          snooze;
    logic          dismiss;
    logic          ringing;
    logic          snoozed;
    logic [2:0]    ring_idx;
    logic [NA-1:0] armed;
    logic          buzzy;
    logic          led;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_alarm_ctrl #(
        .NUM_ALARMS(NA),
        .SNOOZE_MIN(2),
        .RING_TIMEOUT_MIN(3),
        .BEEP_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick_min(tick_min),
        .cur_hour(cur_hour),
        .cur_min(cur_min),
`ifdef ALARM_WEEKDAY_MASK_EN
        .cur_day(cur_day),
        .wr_days(wr_days),
`endif
        .wr_en(wr_en),
        .wr_idx(wr_idx),
        .wr_hour(wr_hour),
        .wr_min(wr_min),
        .wr_enable(wr_enable),
        .snooze(snooze),
        .dismiss(dismiss),
        .ringing(ringing),
        .snoozed(snoozed),
        .ring_idx(ring_idx),
        .armed(armed),
        .buzzy(buzzy),
        .led(led)
    );

    typedef struct {
        string      name;
        logic       tick;
        logic [4:0] hour;
        logic [5:0] min;
        logic [2:0] day;
        logic       wr_en;
        logic [2:0] wr_idx;
        logic [4:0] wr_hour;
        logic [5:0] wr_min;
        logic       wr_enable;
        logic [6:0] wr_days;
        logic       snooze;
        logic       dismiss;
        logic       e_ring;
        logic       e_snz;
        logic [2:0] e_idx;
        logic [3:0] e_armed;
        logic       e_buzzy;
    } vec_t;

    typedef struct {
        string      name;
        logic       ring;
        logic       snz;
        logic [2:0] idx;
        logic [3:0] armed;
        logic       buzzy;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    function automatic vec_t in_nop();
        vec_t v;
        v.name = ""; v.tick = 1'b0; v.hour = '0; v.min = '0; v.day = 3'd1;
        v.wr_en = 1'b0; v.wr_idx = '0; v.wr_hour = '0; v.wr_min = '0;
        v.wr_enable = 1'b0; v.wr_days = 7'h7F; v.snooze = 1'b0; v.dismiss = 1'b0;
        v.e_ring = 1'b0; v.e_snz = 1'b0; v.e_idx = '0; v.e_armed = '0; v.e_buzzy = 1'b0;
        return v;
    endfunction

    function automatic vec_t in_tick(input int h, input int m);
        vec_t v = in_nop();
        v.tick = 1'b1; v.hour = 5'(h); v.min = 6'(m);
        return v;
    endfunction

    function automatic vec_t in_wr(input int idx, input int h, input int m, input logic en);
        vec_t v = in_nop();
        v.wr_en = 1'b1; v.wr_idx = 3'(idx); v.wr_hour = 5'(h); v.wr_min = 6'(m); v.wr_enable = en;
        return v;
    endfunction

    function automatic vec_t in_snz();
        vec_t v = in_nop();
        v.snooze = 1'b1;
        return v;
    endfunction

    function automatic vec_t in_dis();
        vec_t v = in_nop();
        v.dismiss = 1'b1;
        return v;
    endfunction

    task automatic add(input string n, input vec_t v, input logic r, input logic s,
                       input int idx, input logic [3:0] arm, input logic b);
        v.name = n; v.e_ring = r; v.e_snz = s; v.e_idx = 3'(idx); v.e_armed = arm; v.e_buzzy = b;
        tbl.push_back(v);
    endtask

    task automatic compare(input exp_t e);
        logic [10:0] got, want;
        got  = {ringing, snoozed, ring_idx, armed, buzzy, led};
        want = {e.ring, e.snz, e.idx, e.armed, e.buzzy, e.ring | e.snz};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got ring/snz/idx/armed/buzzy/led=%b/%b/%0d/%b/%b/%b want %b/%b/%0d/%b/%b/%b",
                     e.name, ringing, snoozed, ring_idx, armed, buzzy, led,
                     e.ring, e.snz, e.idx, e.armed, e.buzzy, e.ring | e.snz);
        end
    endtask

    task automatic drive_idle();
        tick_min = 1'b0; cur_hour = '0; cur_min = '0;
        wr_en = 1'b0; wr_idx = '0; wr_hour = '0; wr_min = '0; wr_enable = 1'b0;
        snooze = 1'b0; dismiss = 1'b0;
`ifdef ALARM_WEEKDAY_MASK_EN
        cur_day = 3'd1; wr_days = 7'h7F;
`endif
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        tick_min = v.tick; cur_hour = v.hour; cur_min = v.min;
        wr_en = v.wr_en; wr_idx = v.wr_idx; wr_hour = v.wr_hour; wr_min = v.wr_min;
        wr_enable = v.wr_enable; snooze = v.snooze; dismiss = v.dismiss;
`ifdef ALARM_WEEKDAY_MASK_EN
        cur_day = v.day; wr_days = v.wr_days;
`endif
        e.name = v.name; e.ring = v.e_ring; e.snz = v.e_snz;
        e.idx = v.e_idx; e.armed = v.e_armed; e.buzzy = v.e_buzzy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got size 0 want >0");
        end else begin
            compare(exp_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        exp_t z;
        z.ring = 1'b0; z.snz = 1'b0; z.idx = '0; z.armed = '0; z.buzzy = 1'b0;

        // single alarm, buzzer pattern
        add("t1_wr2",      in_wr(2, 7, 30, 1'b1), 0, 0, 0, 4'b0100, 0);
        add("t1_match",    in_tick(7, 30),        1, 0, 2, 4'b0100, 1);
        for (int k = 0; k < 3; k++) add("t1_beep_hi", in_nop(), 1, 0, 2, 4'b0100, 1);
        for (int k = 0; k < 4; k++) add("t1_beep_lo", in_nop(), 1, 0, 2, 4'b0100, 0);
        add("t1_beep_hi2", in_nop(),              1, 0, 2, 4'b0100, 1);
        add("t1_dismiss",  in_dis(),              0, 0, 0, 4'b0100, 0);
        // lowest index wins; matches while ringing are dropped
        add("t2_wr1",      in_wr(1, 6, 0, 1'b1),  0, 0, 0, 4'b0110, 0);
        add("t2_wr3",      in_wr(3, 6, 0, 1'b1),  0, 0, 0, 4'b1110, 0);
        add("t2_prio",     in_tick(6, 0),         1, 0, 1, 4'b1110, 1);
        add("t2_rematch",  in_tick(6, 0),         1, 0, 1, 4'b1110, 1);
        add("t2_dismiss",  in_dis(),              0, 0, 0, 4'b1110, 0);
        // snooze flow
        add("t3_idle_snz", in_snz(),              0, 0, 0, 4'b1110, 0);
        add("t3_idle_dis", in_dis(),              0, 0, 0, 4'b1110, 0);
        add("t3_ring",     in_tick(6, 0),         1, 0, 1, 4'b1110, 1);
        add("t3_snooze",   in_snz(),              0, 1, 1, 4'b1110, 0);
        add("t3_snz_again", in_snz(),             0, 1, 1, 4'b1110, 0);
        add("t3_snz_tick1", in_tick(6, 0),        0, 1, 1, 4'b1110, 0);
        add("t3_snz_tick2", in_tick(12, 0),       1, 0, 1, 4'b1110, 1);
        add("t3_rering",   in_nop(),              1, 0, 1, 4'b1110, 1);
        v = in_snz(); v.dismiss = 1'b1;
        add("t3_snz_dis",  v,                     0, 0, 0, 4'b1110, 0);
        add("t3_ring_b",   in_tick(6, 0),         1, 0, 1, 4'b1110, 1);
        add("t3_snooze_b", in_snz(),              0, 1, 1, 4'b1110, 0);
        add("t3_dis_snzd", in_dis(),              0, 0, 0, 4'b1110, 0);
        // timeout, rejected writes, disarm / retime of the active alarm
        add("t4_ring",     in_tick(6, 0),         1, 0, 1, 4'b1110, 1);
        add("t4_to1",      in_tick(6, 1),         1, 0, 1, 4'b1110, 1);
        add("t4_to2",      in_tick(6, 2),         1, 0, 1, 4'b1110, 1);
        add("t4_timeout",  in_tick(6, 3),         0, 0, 0, 4'b1110, 0);
        add("t4_bad_idx",  in_wr(5, 6, 0, 1'b0),  0, 0, 0, 4'b1110, 0);
        add("t4_bad_min",  in_wr(1, 6, 60, 1'b0), 0, 0, 0, 4'b1110, 0);
        add("t4_bad_hour", in_wr(1, 24, 0, 1'b0), 0, 0, 0, 4'b1110, 0);
        add("t4_intact",   in_tick(6, 0),         1, 0, 1, 4'b1110, 1);
        add("t4_disarm_ring", in_wr(1, 6, 0, 1'b0), 0, 0, 0, 4'b1100, 0);
        add("t4_rearm",    in_wr(1, 6, 0, 1'b1),  0, 0, 0, 4'b1110, 0);
        add("t4_ring2",    in_tick(6, 0),         1, 0, 1, 4'b1110, 1);
        add("t4_retime",   in_wr(1, 9, 0, 1'b1),  1, 0, 1, 4'b1110, 1);
        add("t4_other_off", in_wr(3, 6, 0, 1'b0), 1, 0, 1, 4'b0110, 1);
        add("t4_dismiss2", in_dis(),              0, 0, 0, 4'b0110, 0);
        // event priority
        add("p_ring",      in_tick(9, 0),         1, 0, 1, 4'b0110, 1);
        v = in_tick(9, 1); v.snooze = 1'b1;
        add("p_snz_tick",  v,                     0, 1, 1, 4'b0110, 0);
        add("p_snz_t1",    in_tick(9, 2),         0, 1, 1, 4'b0110, 0);
        add("p_snz_t2",    in_tick(9, 3),         1, 0, 1, 4'b0110, 1);
        v = in_wr(1, 9, 0, 1'b0); v.snooze = 1'b1;
        add("p_disarm_snz", v,                    0, 0, 0, 4'b0100, 0);
        // disarm while snoozed
        add("t5_ring",     in_tick(7, 30),        1, 0, 2, 4'b0100, 1);
        add("t5_snooze",   in_snz(),              0, 1, 2, 4'b0100, 0);
        add("t5_disarm_snzd", in_wr(2, 7, 30, 1'b0), 0, 0, 0, 4'b0000, 0);
`ifdef ALARM_WEEKDAY_MASK_EN
        v = in_wr(0, 8, 0, 1'b1); v.wr_days = 7'b0000010;
        add("wd_wr",       v,                     0, 0, 0, 4'b0001, 0);
        v = in_tick(8, 0); v.day = 3'd2;
        add("wd_day2",     v,                     0, 0, 0, 4'b0001, 0);
        v.day = 3'd7;
        add("wd_day7",     v,                     0, 0, 0, 4'b0001, 0);
        v.day = 3'd1;
        add("wd_day1",     v,                     1, 0, 0, 4'b0001, 1);
        add("wd_dismiss",  in_dis(),              0, 0, 0, 4'b0001, 0);
`endif
        add("r_wr0",       in_wr(0, 1, 0, 1'b1),  0, 0, 0, 4'b0001, 0);
        add("r_ring",      in_tick(1, 0),         1, 0, 0, 4'b0001, 1);

        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        #1;
        z.name = "reset_state";
        compare(z);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // asynchronous reset while ringing, checked before any further clock edge
        #2;
        rst = 1'b1;
        drive_idle();
        #1;
        z.name = "async_reset";
        compare(z);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        v = in_tick(1, 0);
        v.name = "post_rst_disarmed";
        apply(v);
        v = in_tick(0, 0);
        v.name = "post_rst_zero_time";
        apply(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
